// File: rtl/sdp_byte_memory.sv
// Simple dual-port byte-lane memory with a power-up clear sweep and a
// configurable read pipeline (RD_LAT 1 or 2) with selectable read-during-write.
module sdp_byte_memory #(
  parameter int DATA_W   = 32,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W/BYTE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       init_busy,
  output logic                       err
);

  localparam int LANES = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   sweep_addr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                rd_fire;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   pipe_data [RD_LAT];
  logic [RD_LAT-1:0]   pipe_valid;

  assign rd_fire = (state == READY) && rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      sweep_addr <= '0;
      init_busy  <= 1'b1;
      err        <= 1'b0;
    end else begin
      err <= (state == INIT) && (wr_en || rd_en);
      case (state)
        INIT: begin
          // Counter parks at the last address; it only restarts via reset.
          if (sweep_addr == '1) begin
            state     <= READY;
            init_busy <= 1'b0;
          end else begin
            sweep_addr <= sweep_addr + ADDR_W'(1);
          end
        end
        READY:   state <= READY;
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[sweep_addr] <= '0;
      end else if (wr_en) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Word captured by a read; in new-data mode the same-cycle write is merged per lane.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == 1 && wr_en && (wr_addr == rd_addr)) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_be[i]) rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // The array is sampled on the rd_en edge so same-cycle writes cannot leak
  // into old-data reads; the remaining stages only delay the captured word.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) pipe_data[k] <= '0;
    end else begin
      pipe_valid[0] <= rd_fire;
      if (rd_fire) pipe_data[0] <= rd_word;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_data[k]  <= pipe_data[k-1];
      end
      rd_valid <= pipe_valid[RD_LAT-1];
      if (pipe_valid[RD_LAT-1]) rd_data <= pipe_data[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_sdp_byte_memory.sv
// Directed bench: one RD_LAT=1/old-data instance and one RD_LAT=2/new-data
// instance driven by identical stimulus, each checked at its own latency.
module tb_sdp_byte_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] d1, d2;
  logic        v1, v2, busy1, busy2, err1, err2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdp_byte_memory #(.DATA_W(32), .BYTE_W(8), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0)) u_lat1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1),
    .rd_valid(v1), .init_busy(busy1), .err(err1)
  );

  sdp_byte_memory #(.DATA_W(32), .BYTE_W(8), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1)) u_lat2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d2),
    .rd_valid(v2), .init_busy(busy2), .err(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0;
  endtask

  // Single read: lat1 output lands one edge after the sampling edge, lat2 two.
  task automatic rd_one(input logic [3:0] a, input logic [31:0] e1, input logic [31:0] e2);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    chk("lat1_not_early", 32'(v1), 32'd0);
    step();
    chk("lat1_valid", 32'(v1), 32'd1);
    chk("lat1_data", d1, e1);
    chk("lat2_not_early", 32'(v2), 32'd0);
    step();
    chk("lat2_valid", 32'(v2), 32'd1);
    chk("lat2_data", d2, e2);
    chk("lat1_one_pulse", 32'(v1), 32'd0);
  endtask

  initial begin
    int cnt;
    int errs;
    int vs;

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    step(); step(); step();
    chk("rst_rd_data1", d1, 32'd0);
    chk("rst_rd_data2", d2, 32'd0);
    chk("rst_rd_valid", 32'({v1, v2}), 32'd0);
    chk("rst_err", 32'({err1, err2}), 32'd0);
    chk("rst_busy", 32'({busy1, busy2}), 32'd3);

    // Sweep after release, with a dropped read+write at sweep cycle 4.
    reset = 1'b0; cnt = 0; errs = 0; vs = 0;
    while (busy1 && cnt < 40) begin
      wr_en = (cnt == 4); rd_en = (cnt == 4);
      wr_addr = 4'd2; rd_addr = 4'd2; wr_data = 32'h55; wr_be = 4'hF;
      step();
      cnt++;
      if (err1) errs++;
      if (err2) errs++;
      if (v1 || v2) vs++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("init_cycles", 32'(cnt), 32'd16);
    chk("init_busy2_done", 32'(busy2), 32'd0);
    chk("init_err_pulses", 32'(errs), 32'd2);
    chk("init_no_valid", 32'(vs), 32'd0);
    step();
    chk("ready_err_clear", 32'({err1, err2}), 32'd0);

    for (int a = 0; a < 16; a++) rd_one(4'(a), 32'd0, 32'd0);

    wr(4'd3, 32'hDEADBEEF, 4'b1111);
    wr(4'd3, 32'h0000AA00, 4'b0010);
    rd_one(4'd3, 32'hDEADAAEF, 32'hDEADAAEF);

    wr(4'd3, 32'h00000000, 4'b0000);
    chk("zero_be_no_err", 32'({err1, err2}), 32'd0);
    rd_one(4'd3, 32'hDEADAAEF, 32'hDEADAAEF);

    // Same-address read during write.
    wr(4'd5, 32'h11223344, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 4'd5;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk("rdw_old_data", d1, 32'h11223344);
    step();
    chk("rdw_new_data", d2, 32'h1122FFFF);
    rd_one(4'd5, 32'h1122FFFF, 32'h1122FFFF);

    // Different-address read and write in one cycle.
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk("diff_addr_rd1", d1, 32'hDEADAAEF);
    step();
    chk("diff_addr_rd2", d2, 32'hDEADAAEF);
    rd_one(4'd6, 32'hCAFEF00D, 32'hCAFEF00D);

    // Streaming reads of addresses 0..3 holding k+1.
    for (int k = 0; k < 4; k++) wr(4'(k), 32'(k + 1), 4'hF);
    for (int i = 0; i < 7; i++) begin
      rd_en = (i < 4); rd_addr = 4'(i);
      step();
      chk("stream_v1", 32'(v1), 32'((i >= 1 && i <= 4) ? 1 : 0));
      chk("stream_v2", 32'(v2), 32'((i >= 2 && i <= 5) ? 1 : 0));
      if (i >= 1) chk("stream_d1", d1, 32'((i < 4) ? i : 4));
      if (i >= 2) chk("stream_d2", d2, 32'((i - 1 < 4) ? i - 1 : 4));
    end
    rd_en = 1'b0;

    // Reset one cycle after a read is accepted.
    rd_en = 1'b1; rd_addr = 4'd0;
    step();
    rd_en = 1'b0; reset = 1'b1;
    step();
    chk("midrst_valid", 32'({v1, v2}), 32'd0);
    step();
    chk("midrst_d1", d1, 32'd0);
    chk("midrst_d2", d2, 32'd0);
    chk("midrst_busy", 32'({busy1, busy2}), 32'd3);
    reset = 1'b0; cnt = 0; errs = 0; vs = 0;
    while (busy2 && cnt < 40) begin
      step();
      cnt++;
      if (err1 || err2) errs++;
      if (v1 || v2) vs++;
    end
    chk("midrst_init_cycles", 32'(cnt), 32'd16);
    chk("midrst_no_valid", 32'(vs), 32'd0);
    chk("midrst_no_err", 32'(errs), 32'd0);
    rd_one(4'd3, 32'd0, 32'd0);
    rd_one(4'd0, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
